// File: rtl/dec_key_sched_pkg.sv
// Shared types, state encoding and round constants for the
// decryption-side round-key scheduler.
package dec_key_sched_pkg;

    localparam int NR_MAX = 10;

    typedef logic [15:0] rkey_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_SERVE  = 2'd2;

    function automatic logic [7:0] round_const(input logic [3:0] count);
        logic [7:0] rc;
        case (count)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/dec_key_sched_keygen.sv
// Forward key-generation step for the 16-bit AES key schedule:
// keyout = key ^ subByte(key) ^ {rcon(count), 8'h00}.
module dec_key_sched_keygen
    import dec_key_sched_pkg::*;
(
    input  logic [3:0]  count,
    input  logic [15:0] key,
    output logic [15:0] keyout
);

    // Row-major AES S-box; byte 8'h00 occupies the top eight bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    assign keyout = key
                  ^ {sub_byte(key[15:8]), sub_byte(key[7:0])}
                  ^ {round_const(count), 8'h00};

endmodule

// File: rtl/dec_key_sched.sv
// Expands the cipher key forward into a buffer, then streams the
// round keys out in reverse order over a valid/ready handshake.
module dec_key_sched
    import dec_key_sched_pkg::*;
#(
    parameter int NR = 10,
    parameter int KW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] key_in,
    input  logic          key_load,
    output logic          busy,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [KW-1:0] rk_data,
    output logic [3:0]    rk_round,
    output logic          rk_last
);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] ptr;
    rkey_t      key_buf [NR+1];
    rkey_t      cur_key;
    rkey_t      next_key;
    rkey_t      ptr_key;
    rkey_t      dn_key;

    assign busy = (state != ST_IDLE);

    // Read ports: expansion source, current key, and the next-lower key
    // so that back-to-back handshakes need no extra cycle.
    always_comb begin
        cur_key = '0;
        ptr_key = '0;
        dn_key  = '0;
        for (int i = 0; i <= NR; i++) begin
            if (cnt == 4'(i))
                cur_key = key_buf[i];
            if (ptr == 4'(i))
                ptr_key = key_buf[i];
            if (ptr == 4'(i + 1))
                dn_key = key_buf[i];
        end
    end

    dec_key_sched_keygen u_keygen (
        .count  (cnt),
        .key    (cur_key),
        .keyout (next_key)
    );

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && key_load) begin
            key_buf[0] <= key_in;
        end else if (state == ST_EXPAND) begin
            for (int i = 1; i <= NR; i++) begin
                if (cnt == 4'(i - 1))
                    key_buf[i] <= next_key;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (key_load) begin
                        cnt   <= '0;
                        state <= ST_EXPAND;
                    end
                end
                (state == ST_EXPAND): begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NR - 1)) begin
                        state <= ST_SERVE;
                        ptr   <= 4'(NR);
                    end
                end
                (state == ST_SERVE): begin
                    // First SERVE cycle primes the output registers.
                    if (!rk_valid) begin
                        rk_valid <= 1'b1;
                        rk_data  <= ptr_key;
                        rk_round <= ptr;
                        rk_last  <= (ptr == 4'd0);
                    end else if (rk_ready) begin
                        if (ptr == 4'd0) begin
                            state    <= ST_IDLE;
                            rk_valid <= 1'b0;
                            rk_data  <= '0;
                            rk_round <= '0;
                            rk_last  <= 1'b0;
                        end else begin
                            ptr      <= ptr - 4'd1;
                            rk_data  <= dn_key;
                            rk_round <= ptr - 4'd1;
                            rk_last  <= (ptr == 4'd1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dec_key_sched.md
Name: dec_key_sched

Overview:
Decryption-side round-key supplier for the 16-bit AES datapath. The key expansion can only be computed forward: k[i+1] = k[i] ^ subByte(k[i]) ^ rcon(i). This block therefore takes the cipher key, expands it forward through NR rounds into an internal key buffer, then streams the round keys out in reverse order (k[NR] down to k[0]) to the inverse-cipher datapath over a valid/ready handshake. It sits between the key input and the decryption round controller.

Parameters:
NR, 10, number of rounds; legal range 1..10 (rcon is defined only for counts 0..9).
KW, 16, key/round-key width; fixed at 16, present for documentation only.

Ports:
clk  in  1  clock; all flops rise-edge.
rst  in  1  asynchronous, active-high reset.
key_in  in  16  cipher key k[0]; sampled on the key_load cycle only.
key_load  in  1  one-cycle start pulse; accepted only in IDLE.
busy  out  1  high in EXPAND and SERVE.
rk_valid  out  1  round key presented.
rk_ready  in  1  consumer accepts the current key.
rk_data  out  16  round key k[rk_round].
rk_round  out  4  index of the presented key: NR down to 0.
rk_last  out  1  high together with rk_valid when rk_round == 0.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; busy = 0, rk_valid = 0, rk_data = 16'h0000, rk_round = 0, rk_last = 0; round counter = 0. Buffer contents are don't-care.
- Buffer: NR+1 entries of 16 bits, buf[0..NR].
- Forward step: a combinational instance of the existing key-generation unit computes next = cur ^ subByte(cur) ^ rcon(cnt).
  - subByte applies the standard AES S-box to each byte independently.
  - rcon(cnt) = {RC, 8'h00}, with RC = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 for cnt = 0..9.
- IDLE:
  - key_load = 1 → buf[0] <= key_in, cnt <= 0, go to EXPAND; busy is high from the next cycle.
- EXPAND: one key per cycle.
  - buf[cnt+1] <= keygen(buf[cnt], cnt); cnt++.
  - After the write of buf[NR] (NR cycles after the load), go to SERVE with ptr = NR.
- SERVE:
  - rk_valid = 1, rk_data = buf[ptr], rk_round = ptr, rk_last = (ptr == 0).
  - All four outputs are registered and stable while rk_ready = 0.
  - Handshake fires on (rk_valid & rk_ready). On that edge: ptr--, or if ptr was 0, go to IDLE with rk_valid = 0 and busy = 0.
  - Back-to-back acceptance gives one key per cycle.
  - First rk_valid appears exactly NR+1 cycles after the key_load edge.
- key_load while busy: ignored. No restart and no error flag.
- key_load in the same cycle the final handshake fires: ignored. A new load is accepted from IDLE only, i.e. at least one cycle later.
- rk_ready while rk_valid = 0: no effect.
- Reset asserted mid-EXPAND or mid-SERVE: immediate return to IDLE with the reset values above. No partial output after release.
- Counter widths: 4 bits; wrap is impossible because NR ≤ 10.

Decomposition:
- Shared package:
  - rcon table (ROUND_CONST function or array).
  - NR_MAX = 10.
  - State encoding: IDLE/EXPAND/SERVE.
- Sub-module: reuse the existing forward key-generation unit (count, key → keyout) unchanged as the single combinational step instance. Do not duplicate the S-box.
- Buffer is inferred flops; no RAM macro.

Test Plan:
- Zero key: key_in = 16'h0000, rk_ready held 1 → first key at load+11 cycles. Expected buffer k1 = 16'h6263, k2 = 16'hCA98. rk_round sequence 10..0, 11 handshakes. Last beat shows rk_data = 16'h0000 with rk_last = 1, then busy drops.
- Golden compare: 20 random keys, each expanded by a reference model of the forward step → the reverse-order stream matches buf[10..0] exactly for every key.
- Backpressure: rk_ready toggled randomly (≈50%) → rk_data/rk_round hold while not ready. No key skipped or duplicated; the sequence is still 10..0.
- Load while busy: pulse key_load with key_in = 16'hFFFF during EXPAND and again during SERVE → both ignored; the stream still belongs to the original key.
- Async reset: assert rst in SERVE at rk_round = 5, deasserted off-edge → outputs go to the reset values immediately. A new load of 16'h0000 then yields the full 10..0 sequence.
- NR = 1 instance: key_in = 16'h0000 → rk_valid at load+2, stream is 16'h6263 (round 1) then 16'h0000 (round 0, rk_last = 1).
